exe_muldiv: RTL and testbench

- Iterative multiply/divide unit in the EX stage, downstream of the ALU operand-B select.
- Consumes the forwarded operand A (ea) and the selected operand B (b). Executes MULT/MULTU/DIV/DIVU over multiple cycles into HI/LO registers.
- Raises a stall request so the pipeline holds dependent instructions until the result is ready.

---
 rtl/exe_muldiv.sv | 142 ++++++++++++++
 tb/tb_exe_muldiv.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage, writing HI/LO with a pipeline stall request.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divides stay iterative.
module exe_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] b,
  input  logic             estart,
  input  logic [1:0]       emdop,
  input  logic             emfhilo,
  input  logic             eflush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hreg, lreg, breg;
  logic             op_mul, neg_q, neg_r, dz;

  logic             accept, op_is_mul, sgn;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   msum, dtmp;
  logic [WIDTH-1:0] ddiff;
  logic             dge;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0] hi_fin, lo_fin;

  assign op_is_mul = ~emdop[1];
  assign sgn       = ~emdop[0];
  assign a_abs     = (sgn && ea[WIDTH-1]) ? -ea : ea;
  assign b_abs     = (sgn && b[WIDTH-1])  ? -b  : b;
  assign accept    = (state == IDLE) & estart & ~eflush;

  assign busy  = (state != IDLE);
  assign stall = busy & (estart | emfhilo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
`ifdef MULDIV_FAST_MUL_EN
        if (accept) state_nx = op_is_mul ? FIN : CALC;
`else
        if (accept) state_nx = CALC;
`endif
      end
      CALC: begin
        if (eflush)                      state_nx = IDLE;
        else if (cnt == CW'(WIDTH - 1))  state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // hreg/lreg hold {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    msum     = {1'b0, hreg} + (lreg[0] ? {1'b0, breg} : '0);
    dtmp     = {hreg, lreg[WIDTH-1]};
    dge      = (dtmp >= {1'b0, breg});
    ddiff    = dtmp[WIDTH-1:0] - breg;
    prod_fin = neg_q ? -{hreg, lreg} : {hreg, lreg};
    hi_fin   = '0;
    lo_fin   = '0;
    if (op_mul) begin
      hi_fin = prod_fin[2*WIDTH-1:WIDTH];
      lo_fin = prod_fin[WIDTH-1:0];
    end else begin
      hi_fin = neg_r ? -hreg : hreg;
      lo_fin = dz ? '1 : (neg_q ? -lreg : lreg);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      hreg   <= '0;
      lreg   <= '0;
      breg   <= '0;
      op_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            op_mul <= op_is_mul;
            neg_q  <= sgn & (ea[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn & ea[WIDTH-1];
            dz     <= ~op_is_mul & (b == '0);
            hreg   <= '0;
            breg   <= op_is_mul ? a_abs : b_abs;
            lreg   <= op_is_mul ? b_abs : a_abs;
`ifdef MULDIV_FAST_MUL_EN
            if (op_is_mul) {hreg, lreg} <= {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
`endif
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_mul) begin
            hreg <= msum[WIDTH:1];
            lreg <= {msum[0], lreg[WIDTH-1:1]};
          end else begin
            hreg <= dge ? ddiff : dtmp[WIDTH-1:0];
            lreg <= {lreg[WIDTH-2:0], dge};
          end
        end
        FIN: begin
          if (!eflush) begin
            hi   <= hi_fin;
            lo   <= lo_fin;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed corner cases plus random ops against an arithmetic reference.
module tb_exe_muldiv;

  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam logic [1:0] LONG_OP = 2'b11;
`else
  localparam logic [1:0] LONG_OP = 2'b00;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ea, b;
  logic         estart, emfhilo, eflush;
  logic [1:0]   emdop;
  logic [W-1:0] hi, lo;
  logic         busy, done, stall;

  int vectors = 0;
  int miscompares = 0;

  exe_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ea(ea), .b(b), .estart(estart), .emdop(emdop),
    .emfhilo(emfhilo), .eflush(eflush), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    longint sa, sd, q, r;
    logic [63:0] res;
    sa = $signed(a);
    sd = $signed(d);
    res = '0;
    case (op)
      2'b00: begin q = sa * sd; res = q; end
      2'b01: res = {32'h0, a} * {32'h0, d};
      2'b10: begin
        if (d == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sd;
          r = sa % sd;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (d == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % d, a / d};
      end
    endcase
    return res;
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
    return op[1] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] expv;
    int cycles, dones;
    expv = ref_model(op, a, d);
    @(negedge clk);
    ea = a; b = d; emdop = op; estart = 1'b1;
    @(posedge clk); #1;
    estart = 1'b0;
    cycles = 0;
    dones = 0;
    while (busy && cycles < 100) begin
      if (done) dones++;
      @(posedge clk); #1;
      cycles++;
    end
    chk({tag, "_lat"}, cycles, exp_lat(op));
    chk({tag, "_early_done"}, dones, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_hilo"}, {hi, lo}, expv);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int cycles, dones, stall_low;
    rst = 1'b1; ea = '0; b = '0; estart = 1'b0; emdop = '0; emfhilo = 1'b0; eflush = 1'b0;
    #1;
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op("mult_6x7", 2'b00, 32'd6, 32'd7);
    chk("mult_6x7_lo", lo, 42);
    do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu_zero", 2'b11, 32'd100, 32'd0);
    chk("divu_zero_const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op("div_negzero", 2'b10, 32'hFFFF_FFFB, 32'd0);
    chk("div_negzero_const", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);

    // MFHI/MFLO held behind a DIVU until HI/LO are final
    @(negedge clk);
    ea = 32'd10; b = 32'd3; emdop = 2'b11; estart = 1'b1;
    @(posedge clk); #1;
    estart = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    emfhilo = 1'b1;
    #1;
    cycles = 5;
    stall_low = 0;
    while (busy && cycles < 100) begin
      if (!stall) stall_low++;
      @(posedge clk); #1;
      cycles++;
    end
    chk("stall_held", stall_low, 0);
    chk("stall_lat", cycles, 33);
    chk("stall_release", stall, 0);
    chk("stall_read", {hi, lo}, 64'h0000_0001_0000_0003);
    emfhilo = 1'b0;

    @(negedge clk);
    emfhilo = 1'b1;
    #1;
    chk("stall_idle", stall, 0);
    emfhilo = 1'b0;

    do_op("preload", 2'b11, 32'h1234 * 32'h1236, 32'h1235);
    chk("preload_const", {hi, lo}, 64'h0000_1234_0000_1234);

    // flush mid-operation
    @(negedge clk);
    ea = 32'd5; b = 32'd5; emdop = LONG_OP; estart = 1'b1;
    @(posedge clk); #1;
    estart = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("flush_busy_pre", busy, 1);
    eflush = 1'b1;
    @(posedge clk); #1;
    eflush = 1'b0;
    chk("flush_idle", busy, 0);
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dones++; end
    chk("flush_no_done", dones, 0);
    chk("flush_hilo", {hi, lo}, 64'h0000_1234_0000_1234);

    // flush beats start on the same edge
    @(negedge clk);
    ea = 32'd9; b = 32'd3; emdop = 2'b11; estart = 1'b1; eflush = 1'b1;
    @(posedge clk); #1;
    estart = 1'b0; eflush = 1'b0;
    chk("flush_start_busy", busy, 0);

    // async reset mid-operation, with a second start held by stall
    @(negedge clk);
    ea = 32'd25; b = 32'd5; emdop = LONG_OP; estart = 1'b1;
    @(posedge clk); #1;
    estart = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    estart = 1'b1;
    #1;
    chk("busy_start_stall", stall, 1);
    repeat (15) begin @(posedge clk); #1; end
    chk("rst_mid_busy_pre", busy, 1);
    rst = 1'b1; estart = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_hilo", {hi, lo}, 64'h0);
    chk("rst_mid_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      do_op("rand", op, pick(), pick());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
